// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle controller.
// Contents: FSM state encoding, instruction classes, opcode/funct constants,
// and the encodings of the ext_sel, pc_src, wb_sel and reg_dst selects.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  // Instruction classes seen by the FSM; shifts are split from other
  // R-type operations because they take their B operand from the extender.
  typedef enum logic [3:0] {
    IC_RTYPE,
    IC_SHIFT,
    IC_IALU,
    IC_LUI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_BNE,
    IC_J,
    IC_JAL,
    IC_SYSCALL,
    IC_ILLEGAL
  } iclass_e;

  // Opcodes (ir[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (ir[5:0])
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // Extender mode
  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_SHAMT = 2'd2;
  localparam logic [1:0] EXT_NONE  = 2'd3;

  // PC source
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Writeback source
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_LUI  = 2'd3;

  // Destination register select
  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_LINK = 2'd2;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction decoder for the multi-cycle controller.
// Ports:
//   ir      in  32  instruction from the IR register
//   iclass  out     instruction class consumed by the FSM
//   ext_sel out  2  extender mode for this instruction
//   illegal out  1  opcode or R-type funct not supported
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_e     iclass,
  output logic [1:0]  ext_sel,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_ir_bits;

  assign op = ir[31:26];
  assign fn = ir[5:0];
  // Register and immediate fields are routed by the datapath, not here.
  assign unused_ir_bits = ^ir[25:6];

  // NOTE: every signal written in an always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    iclass = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: iclass = IC_SHIFT;
          FN_SYSCALL:             iclass = IC_SYSCALL;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:        iclass = IC_RTYPE;
          default:                iclass = IC_ILLEGAL;
        endcase
      end
      OP_J:                          iclass = IC_J;
      OP_JAL:                        iclass = IC_JAL;
      OP_BEQ:                        iclass = IC_BEQ;
      OP_BNE:                        iclass = IC_BNE;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI:      iclass = IC_IALU;
      OP_LUI:                        iclass = IC_LUI;
      OP_LW:                         iclass = IC_LW;
      OP_SW:                         iclass = IC_SW;
      default:                       iclass = IC_ILLEGAL;
    endcase
  end

  // Logical immediates are zero-extended; arithmetic, compare, address and
  // branch offsets are sign-extended; lui shifts the raw imm16 elsewhere.
  always_comb begin
    ext_sel = EXT_NONE;
    case (iclass)
      IC_SHIFT:                   ext_sel = EXT_SHAMT;
      IC_LW, IC_SW, IC_BEQ, IC_BNE: ext_sel = EXT_SIGN;
      IC_IALU: begin
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ext_sel = EXT_ZERO;
        else                                                  ext_sel = EXT_SIGN;
      end
      default:                    ext_sel = EXT_NONE;
    endcase
  end

  assign illegal = (iclass == IC_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS core: sequences FETCH, DECODE, EXEC,
// MEM and WB over the shared datapath and drives every datapath enable.
// Parameters:
//   FETCH_TIMEOUT  max mem_ready wait in FETCH/MEM (0 = wait forever)
//   JAL_REG        link register index (applied by the datapath via reg_dst)
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   ir                 current instruction
//   mem_ready          memory request completes this cycle
//   alu_zero           ALU zero flag for beq/bne
//   mem_req, mem_we, addr_sel          memory port control
//   ir_we, pc_we, pc_src               IR / PC load control
//   ext_sel, alu_src_b                 extender mode, ALU B operand select
//   reg_we, reg_dst, wb_sel            register file write control
//   halted, fault                      sticky status
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 0,
  parameter int JAL_REG       = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  ext_sel,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        fault
);

  localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

  state_e      state, state_next;
  iclass_e     iclass;
  logic [1:0]  dec_ext_sel;
  logic        dec_illegal;
  logic        fault_q, set_fault;
  logic [TW-1:0] tmo_cnt;
  logic [TW:0]   tmo_cnt_inc;
  logic        timeout_hit;
  logic [4:0]  unused_jal_reg;

  // Un-gated versions of the outputs, decoded from state + ir.
  logic       mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c;
  logic       alu_src_b_c, reg_we_c;
  logic [1:0] pc_src_c, ext_sel_c, reg_dst_c, wb_sel_c;

  // The link index is applied in the datapath register-address mux.
  assign unused_jal_reg = 5'(JAL_REG);

  mips_ctrl_decode u_decode (
    .ir      (ir),
    .iclass  (iclass),
    .ext_sel (dec_ext_sel),
    .illegal (dec_illegal)
  );

  // The count is the number of not-ready cycles already spent; this cycle
  // being not-ready as well makes it the FETCH_TIMEOUT-th one.
  assign tmo_cnt_inc = {1'b0, tmo_cnt} + (TW + 1)'(1);
  assign timeout_hit = (FETCH_TIMEOUT != 0) && !mem_ready &&
                       (tmo_cnt_inc == (TW + 1)'(FETCH_TIMEOUT));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_FETCH;
      fault_q <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (set_fault) fault_q <= 1'b1;
      // Any state change clears the counter, covering entry to FETCH/MEM.
      if (state_next != state)
        tmo_cnt <= '0;
      else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready)
        tmo_cnt <= tmo_cnt_inc[TW-1:0];
    end
  end

  always_comb begin
    state_next  = state;
    set_fault   = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_src_c    = PC_SEQ;
    ext_sel_c   = EXT_NONE;
    alu_src_b_c = 1'b0;
    reg_we_c    = 1'b0;
    reg_dst_c   = DST_RT;
    wb_sel_c    = WB_ALU;

    case (state)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c    = 1'b1;
          pc_we_c    = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          set_fault  = 1'b1;
          state_next = ST_HALT;
        end
      end

      ST_DECODE: begin
        ext_sel_c = dec_ext_sel;
        if (dec_illegal) begin
          set_fault  = 1'b1;
          state_next = ST_HALT;
        end else if (iclass == IC_SYSCALL) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        ext_sel_c   = dec_ext_sel;
        alu_src_b_c = (iclass == IC_SHIFT) || (iclass == IC_IALU) ||
                      (iclass == IC_LUI)   || (iclass == IC_LW)   ||
                      (iclass == IC_SW);
        case (iclass)
          IC_BEQ, IC_BNE: begin
            // bne is taken on a non-zero comparison result.
            if (alu_zero == (iclass == IC_BEQ)) begin
              pc_we_c  = 1'b1;
              pc_src_c = PC_BRANCH;
            end
            state_next = ST_FETCH;
          end
          IC_J, IC_JAL: begin
            pc_we_c  = 1'b1;
            pc_src_c = PC_JUMP;
            // The link value is the already-incremented PC, still valid
            // in this cycle because the PC loads at the clock edge.
            if (iclass == IC_JAL) begin
              reg_we_c  = 1'b1;
              reg_dst_c = DST_LINK;
              wb_sel_c  = WB_LINK;
            end
            state_next = ST_FETCH;
          end
          IC_LW, IC_SW: state_next = ST_MEM;
          default:      state_next = ST_WB;
        endcase
      end

      ST_MEM: begin
        ext_sel_c  = dec_ext_sel;
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = (iclass == IC_SW);
        if (mem_ready) begin
          state_next = (iclass == IC_SW) ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          set_fault  = 1'b1;
          state_next = ST_HALT;
        end
      end

      ST_WB: begin
        ext_sel_c = dec_ext_sel;
        reg_we_c  = 1'b1;
        reg_dst_c = (iclass == IC_RTYPE || iclass == IC_SHIFT) ? DST_RD : DST_RT;
        if (iclass == IC_LW)       wb_sel_c = WB_MEM;
        else if (iclass == IC_LUI) wb_sel_c = WB_LUI;
        state_next = ST_FETCH;
      end

      ST_HALT: state_next = ST_HALT;

      default: state_next = ST_FETCH;
    endcase
  end

  // While reset is asserted the outputs are forced idle immediately, so an
  // in-flight memory request drops without a completion cycle.
  assign mem_req   = rst_n & mem_req_c;
  assign mem_we    = rst_n & mem_we_c;
  assign addr_sel  = rst_n & addr_sel_c;
  assign ir_we     = rst_n & ir_we_c;
  assign pc_we     = rst_n & pc_we_c;
  assign pc_src    = rst_n ? pc_src_c : PC_SEQ;
  assign ext_sel   = rst_n ? ext_sel_c : EXT_NONE;
  assign alu_src_b = rst_n & alu_src_b_c;
  assign reg_we    = rst_n & reg_we_c;
  assign reg_dst   = rst_n ? reg_dst_c : DST_RT;
  assign wb_sel    = rst_n ? wb_sel_c : WB_ALU;
  assign halted    = rst_n & (state == ST_HALT);
  assign fault     = rst_n & fault_q;

endmodule
